// File: rtl/rot_pkg.sv
// Shared definitions for the rotate/shift pipeline: operation encoding.
package rot_pkg;

    typedef enum logic [1:0] {
        ROT_R = 2'b00,
        ROT_L = 2'b01,
        SHR_L = 2'b10,
        SHR_A = 2'b11
    } rot_mode_t;

endpackage

// File: rtl/rot_stage.sv
// One registered pipeline stage: conditionally shifts/rotates by 2^K when amount bit K is set.
module rot_stage
    import rot_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    input  logic [W-1:0]         d_in,
    input  rot_mode_t            mode_in,
    input  logic [$clog2(W)-1:0] amt_in,
    output logic [W-1:0]         d_out,
    output rot_mode_t            mode_out,
    output logic [$clog2(W)-1:0] amt_out
);

    localparam int SW = $clog2(W);
    localparam int S  = 1 << K;

    logic [W-1:0]  d_nxt;
    logic [SW-1:0] amt_nxt;

    always_comb begin
        d_nxt   = d_in;
        amt_nxt = amt_in;
        // Bit K is consumed here; later stages only see the bits still pending.
        amt_nxt[K] = 1'b0;
        if (amt_in[K]) begin
            case (mode_in)
                ROT_R: d_nxt = {d_in[S-1:0], d_in[W-1:S]};
                ROT_L: d_nxt = {d_in[W-S-1:0], d_in[W-1:W-S]};
                SHR_L: d_nxt = {{S{1'b0}}, d_in[W-1:S]};
                SHR_A: d_nxt = {{S{d_in[W-1]}}, d_in[W-1:S]};
                default: d_nxt = d_in;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_out    <= '0;
            mode_out <= ROT_R;
            amt_out  <= '0;
        end else if (adv) begin
            d_out    <= d_nxt;
            mode_out <= mode_in;
            amt_out  <= amt_nxt;
        end
    end

endmodule

// File: rtl/rot_shift_pipe.sv
// Pipelined barrel rotator/shifter with valid/ready flow control; log2(W) stages.
module rot_shift_pipe
    import rot_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [$clog2(W)-1:0] in_amt,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_zero
);

    localparam int SW = $clog2(W);

    logic                  advance;
    logic [SW-1:0]         vld;
    logic [SW-1:0][W-1:0]  dat_c;
    rot_mode_t [SW-1:0]    mode_c;
    logic [SW-1:0][SW-1:0] amt_c;
    rot_mode_t             mode_unused;
    logic [SW-1:0]         amt_unused;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[SW-1];
    // Gated by valid so the reset value of the final data register reads as non-zero-flagged.
    assign out_zero  = out_valid && (out_data == '0);

    assign dat_c[0]  = in_data;
    assign mode_c[0] = rot_mode_t'(in_mode);
    assign amt_c[0]  = in_amt;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        if (k < SW - 1) begin : g_mid
            rot_stage #(.W(W), .K(k)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .adv      (advance),
                .d_in     (dat_c[k]),
                .mode_in  (mode_c[k]),
                .amt_in   (amt_c[k]),
                .d_out    (dat_c[k+1]),
                .mode_out (mode_c[k+1]),
                .amt_out  (amt_c[k+1])
            );
        end else begin : g_last
            rot_stage #(.W(W), .K(k)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .adv      (advance),
                .d_in     (dat_c[k]),
                .mode_in  (mode_c[k]),
                .amt_in   (amt_c[k]),
                .d_out    (out_data),
                .mode_out (mode_unused),
                .amt_out  (amt_unused)
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (advance) begin
            vld[0] <= in_valid;
            for (int k = 1; k < SW; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

endmodule

// File: tb/tb_rot_shift_pipe.sv
// Self-checking bench for rot_shift_pipe at W=8 and W=32 with a queue scoreboard and bit-level model.
module tb_rot_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, oz8;
    logic [7:0]  id8 = '0, od8;
    logic [2:0]  ia8 = '0;
    logic [1:0]  im8 = '0;

    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, oz32;
    logic [31:0] id32 = '0, od32;
    logic [4:0]  ia32 = '0;
    logic [1:0]  im32 = '0;

    int total = 0;
    int bad   = 0;

    logic [63:0] q8[$];
    logic [63:0] q32[$];

    always #5 clk = ~clk;

    rot_shift_pipe #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_amt(ia8), .in_mode(im8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_zero(oz8)
    );

    rot_shift_pipe #(.W(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_amt(ia32), .in_mode(im32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_zero(oz32)
    );

    function automatic logic [63:0] model(input logic [63:0] d, input int w, input int n,
                                          input logic [1:0] m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                2'b00:   r[i] = d[(i + n) % w];
                2'b01:   r[i] = d[(i - n + w) % w];
                2'b10:   r[i] = (i + n < w) ? d[i + n] : 1'b0;
                default: r[i] = (i + n < w) ? d[i + n] : d[w - 1];
            endcase
        end
        return r;
    endfunction

    // One clock: handshakes are sampled at the falling edge, inputs change 1 time unit after the rising edge.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (!rst_n) begin
            q8.delete();
            q32.delete();
        end else begin
            if (iv8 && ir8)
                q8.push_back(model({56'b0, id8}, 8, int'(ia8), im8));
            if (iv32 && ir32)
                q32.push_back(model({32'b0, id32}, 32, int'(ia32), im32));
            if (ov8 && or8) begin
                total++;
                if (q8.size() == 0) begin
                    bad++;
                    $display("FAIL sb8_unexpected got=%h expected no beat", od8);
                end else begin
                    e = q8.pop_front();
                    if (od8 !== e[7:0]) begin
                        bad++;
                        $display("FAIL sb8_data got=%h exp=%h", od8, e[7:0]);
                    end
                    total++;
                    if (oz8 !== (e[7:0] == 8'h00)) begin
                        bad++;
                        $display("FAIL sb8_zero got=%b exp=%b", oz8, (e[7:0] == 8'h00));
                    end
                end
            end
            if (ov32 && or32) begin
                total++;
                if (q32.size() == 0) begin
                    bad++;
                    $display("FAIL sb32_unexpected got=%h expected no beat", od32);
                end else begin
                    e = q32.pop_front();
                    if (od32 !== e[31:0]) begin
                        bad++;
                        $display("FAIL sb32_data got=%h exp=%h", od32, e[31:0]);
                    end
                    total++;
                    if (oz32 !== (e[31:0] == 32'h0)) begin
                        bad++;
                        $display("FAIL sb32_zero got=%b exp=%b", oz32, (e[31:0] == 32'h0));
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        iv8 = 1'b0; or8 = 1'b1; iv32 = 1'b0; or32 = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        total++; if (ov8 !== 1'b0)   begin bad++; $display("FAIL rst_ov8 got=%b exp=0", ov8); end
        total++; if (od8 !== 8'h00)  begin bad++; $display("FAIL rst_od8 got=%h exp=00", od8); end
        total++; if (oz8 !== 1'b0)   begin bad++; $display("FAIL rst_oz8 got=%b exp=0", oz8); end
        total++; if (ir8 !== 1'b1)   begin bad++; $display("FAIL rst_ir8 got=%b exp=1", ir8); end
        total++; if (ov32 !== 1'b0)  begin bad++; $display("FAIL rst_ov32 got=%b exp=0", ov32); end
        total++; if (ir32 !== 1'b1)  begin bad++; $display("FAIL rst_ir32 got=%b exp=1", ir32); end
    endtask

    task automatic send_one(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                            input logic [7:0] exp_d, input logic exp_z);
        or8 = 1'b1;
        iv8 = 1'b1; id8 = d; ia8 = a; im8 = m;
        tick();
        iv8 = 1'b0; id8 = 8'h5C;
        tick();
        total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL lat_early d=%h got=%b exp=0", d, ov8); end
        tick();
        total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL lat_due d=%h got=%b exp=1", d, ov8); end
        total++; if (od8 !== exp_d) begin bad++; $display("FAIL dir_data d=%h got=%h exp=%h", d, od8, exp_d); end
        total++; if (oz8 !== exp_z) begin bad++; $display("FAIL dir_zero d=%h got=%b exp=%b", d, oz8, exp_z); end
        tick();
    endtask

    task automatic test_directed();
        send_one(8'hB4, 3'd1, 2'b00, 8'h5A, 1'b0);
        send_one(8'h81, 3'd3, 2'b01, 8'h0C, 1'b0);
        send_one(8'h90, 3'd2, 2'b11, 8'hE4, 1'b0);
        send_one(8'hFF, 3'd7, 2'b10, 8'h01, 1'b0);
        send_one(8'h80, 3'd7, 2'b10, 8'h01, 1'b0);
        send_one(8'h01, 3'd1, 2'b10, 8'h00, 1'b1);
        send_one(8'hA5, 3'd0, 2'b11, 8'hA5, 1'b0);
        drain();
    endtask

    task automatic run_pattern(input string name, input logic [15:0] vpat);
        logic [15:0] seen;
        logic [15:0] want;
        seen = '0;
        want = vpat << 2;
        or8 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            iv8 = vpat[c];
            id8 = 8'($urandom);
            ia8 = 3'($urandom_range(0, 7));
            im8 = 2'($urandom_range(0, 3));
            tick();
            seen[c] = ov8;
        end
        iv8 = 1'b0;
        total++;
        if (seen !== want) begin
            bad++;
            $display("FAIL %s valid_seq got=%b exp=%b", name, seen, want);
        end
        total++;
        if (q8.size() != 0) begin
            bad++;
            $display("FAIL %s leftover got=%0d exp=0", name, q8.size());
        end
    endtask

    task automatic test_back_to_back();
        run_pattern("b2b", 16'h00FF);
    endtask

    task automatic test_bubbles();
        run_pattern("bubble", 16'h00B5);
    endtask

    task automatic test_stall();
        logic [7:0] hold;
        or8 = 1'b1;
        iv8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id8 = 8'($urandom); ia8 = 3'($urandom_range(1, 7)); im8 = 2'($urandom_range(0, 3));
            tick();
        end
        or8 = 1'b0;
        hold = od8;
        id8 = 8'h3C; ia8 = 3'd2; im8 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ir8 !== 1'b0) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=0", i, ir8); end
            total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL stall_valid c=%0d got=%b exp=1", i, ov8); end
            total++; if (od8 !== hold) begin bad++; $display("FAIL stall_data c=%0d got=%h exp=%h", i, od8, hold); end
        end
        or8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (6) tick();
        total++;
        if (q8.size() != 0) begin
            bad++;
            $display("FAIL stall_lost got=%0d pending exp=0", q8.size());
        end
    endtask

    task automatic test_reset_flush();
        int seen_valid;
        seen_valid = 0;
        or8 = 1'b0;
        iv8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id8 = 8'($urandom); ia8 = 3'($urandom_range(0, 7)); im8 = 2'($urandom_range(0, 3));
            tick();
        end
        iv8 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (ov8 !== 1'b0)  begin bad++; $display("FAIL flush_valid got=%b exp=0", ov8); end
        total++; if (ir8 !== 1'b1)  begin bad++; $display("FAIL flush_ready got=%b exp=1", ir8); end
        total++; if (od8 !== 8'h00) begin bad++; $display("FAIL flush_data got=%h exp=00", od8); end
        or8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov8) seen_valid++;
        end
        total++;
        if (seen_valid != 0) begin
            bad++;
            $display("FAIL flush_stale got=%0d beats exp=0", seen_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            iv8  = 1'($urandom_range(0, 1));
            id8  = 8'($urandom);
            ia8  = 3'($urandom_range(0, 7));
            im8  = 2'($urandom_range(0, 3));
            or8  = ($urandom_range(0, 3) != 0);
            iv32 = 1'($urandom_range(0, 1));
            id32 = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            ia32 = 5'($urandom_range(0, 31));
            im32 = 2'($urandom_range(0, 3));
            or32 = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
        total++; if (q8.size() != 0)  begin bad++; $display("FAIL rand8_left got=%0d exp=0", q8.size()); end
        total++; if (q32.size() != 0) begin bad++; $display("FAIL rand32_left got=%0d exp=0", q32.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        drain();
        test_bubbles();
        drain();
        test_stall();
        drain();
        test_reset_flush();
        drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rot_shift_pipe.md
ROT_SHIFT_PIPE -- requirements
Module: rot_shift_pipe

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width; legal values are powers of two, 2..64.
REQ-002 The block SHALL derive localparam SW = clog2(W), the shift-amount width and the pipeline stage count.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the input beat this cycle.
REQ-007 in_data  input  W  operand.
REQ-008 in_amt  input  SW  shift/rotate amount, 0..W-1.
REQ-009 in_mode  input  2  operation: 00 rotate right, 01 rotate left, 10 logical shift right, 11 arithmetic shift right.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result beat.
REQ-012 out_data  output  W  result.
REQ-013 out_zero  output  1  high when out_data is all zeros; valid only with out_valid.

Function
REQ-014 Rotate right by n SHALL give out_data[i] = in_data[(i+n) mod W].
REQ-015 Rotate left by n SHALL give out_data[i] = in_data[(i-n) mod W].
REQ-016 Logical shift right SHALL zero-fill the top n bits; arithmetic shift right SHALL fill them with in_data[W-1].
REQ-017 An amount of 0 SHALL pass the data unchanged in every mode.
REQ-018 The datapath SHALL be SW registered stages; stage k (k=0..SW-1) SHALL shift or rotate by 2^k when amt bit k is set, else pass through.
REQ-019 Each stage SHALL carry its own valid bit, the mode, and the amount bits not yet consumed.
REQ-020 Pipeline advance SHALL be advance = !out_valid || out_ready; all stages SHALL move together only when advance is high.
REQ-021 in_ready SHALL equal advance (combinational), and a beat SHALL be accepted when in_valid && in_ready.
REQ-022 Latency: a beat accepted at edge N with the output not stalled SHALL present out_valid=1 after edge N+SW-1.
REQ-023 Throughput SHALL be one beat per cycle while out_ready is held high.
REQ-024 Bubbles SHALL propagate as invalid stages and SHALL NOT be compressed.
REQ-025 While out_valid && !out_ready: out_data, out_zero and out_valid SHALL hold stable, and no stage SHALL change.
REQ-026 in_valid low while in_ready is high SHALL inject a bubble; in_data SHALL then be ignored.
REQ-027 Results SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-028 out_zero SHALL be computed from the final-stage data register, not from a separate pipeline.

Reset
REQ-029 While rst_n=0 at a clock edge, every stage valid bit SHALL clear, giving out_valid=0 from the following cycle.
REQ-030 out_data and out_zero SHALL reset to 0; reset of internal data registers is optional.
REQ-031 A reset mid-stream SHALL discard all in-flight beats, and none SHALL appear afterwards.
REQ-032 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-033 Package rot_pkg SHALL hold the mode encoding constants (ROT_R, ROT_L, SHR_L, SHR_A) and the 2-bit mode typedef.
REQ-034 Sub-module rot_stage SHALL implement one conditional shift-by-2^k stage, with parameters W and K, instantiated SW times via generate.
REQ-035 The top level SHALL own the valid chain and the stall logic only.

Verification (W=8, latency 3)
REQ-036 8'hB4, amt 1, mode 00 -> out_data 8'h5A three cycles later, out_zero 0.
REQ-037 8'h81, amt 3, mode 01 -> 8'h0C; 8'h90, amt 2, mode 11 -> 8'hE4; 8'hFF, amt 7, mode 10 -> 8'h01; 8'h80, amt 7, mode 10 -> 8'h01; 8'h01, amt 1, mode 10 -> 8'h00 with out_zero 1.
REQ-038 Eight back-to-back beats with out_ready=1 -> eight consecutive out_valid cycles with results in order, then out_valid drops.
REQ-039 Pipeline full, out_ready=0 for 4 cycles -> in_ready=0 and out_data frozen; on release, all beats emerge in order with no loss.
REQ-040 rst_n pulsed low for one cycle with 3 beats in flight -> out_valid=0 next cycle, and no stale beat ever emerges.
REQ-041 Random mode, amount, data and ready pattern, W=8 and W=32 -> scoreboard match against a reference model.
